camera_config_sequencer: RTL and testbench
==========================================

# camera_config_sequencer

Walks a table of 16-bit camera register writes, {8-bit register address, 8-bit data}, and issues each entry to the I2C write master one at a time. The I2C master runs on its own slow derived clock. This block sits between the camera-init ROM and the I2C master, and releases the capture pipeline once configuration is complete. The table can also request millisecond settle delays and flag its own end.

## Interface
- `ROM_AW`, default 6: table address width, giving 2^ROM_AW entries.
- `DELAY_UNIT`, default 100_000: `clk_i` cycles per delay unit (1 ms at 100 MHz).
- `DONE_TIMEOUT`, default 2_000_000: maximum `clk_i` cycles to wait for `i2c_done_i`.
- `clk_i` in, 1: system clock. One clock only.
- `reset_ni` in, 1: reset, asynchronous, active-low.
- `start_i` in, 1: level. Begins a sequence when the block is in IDLE.
- `rom_addr_o` out, ROM_AW: table address.
- `rom_data_i` in, 16: table word. Synchronous ROM, valid 1 cycle after the address.
- `i2c_write_data_o` out, 16: {reg, data} driven to the I2C master.
- `i2c_valid_o` out, 1: write request to the I2C master.
- `i2c_ready_i` in, 1: I2C master idle.
- `i2c_done_i` in, 1: I2C master transfer complete. High for about 1 slow-clock period.
- `busy_o` out, 1: a sequence is in progress.
- `config_done_o` out, 1: sticky, last sequence completed with no error.
- `error_o` out, 1: sticky, last sequence aborted on timeout.

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, FINISH.
- IDLE:
  - `start_i` = 1 → FETCH. Index cleared to 0, `config_done_o` and `error_o` cleared.
- FETCH:
  - Drive `rom_addr_o` = index, then → DECODE on the next cycle.
- DECODE, on `rom_data_i`:
  - 16'hFFFF is the end marker → FINISH.
  - 16'hFExx is a delay → DELAY. Count = xx·DELAY_UNIT. xx = 0 means no wait.
  - Any other value is latched into `i2c_write_data_o` → ISSUE.
- ISSUE:
  - Wait for `i2c_ready_i` = 1, then raise `i2c_valid_o` → WAIT_ACCEPT.
- WAIT_ACCEPT:
  - Hold `i2c_valid_o` = 1 until `i2c_ready_i` = 0, then drop `i2c_valid_o` → WAIT_DONE.
- WAIT_DONE:
  - On the rising edge of `i2c_done_i` (registered edge detect), index++ → FETCH.
- DELAY:
  - Down-count to 0, then index++ → FETCH.
- FINISH:
  - `config_done_o` = 1 → IDLE.
- Index wrap: if index reaches 2^ROM_AW − 1 without an end marker, that entry is processed and then → FINISH. The index never wraps to 0.
- `i2c_write_data_o` is held constant from ISSUE until the next DECODE of a write entry.
- Timeout:
  - One counter spans WAIT_ACCEPT plus WAIT_DONE.
  - Reaching DONE_TIMEOUT sets `error_o`, drops `i2c_valid_o` → IDLE.
  - `config_done_o` stays 0.
- `start_i` outside IDLE is ignored. A `start_i` still high on return to IDLE restarts the sequence.
- `busy_o` = 1 in every state except IDLE.

## Timing
- Reset (async assert, sync deassert inside):
  - state IDLE, index 0.
  - `rom_addr_o` 0, `i2c_write_data_o` 0.
  - `i2c_valid_o`, `busy_o`, `config_done_o`, `error_o` all 0.
  - Counters 0, edge-detect register 0.
- Reset mid-transfer drops `i2c_valid_o` immediately. A half-sent I2C frame is the I2C master's concern.
- `start_i` → `busy_o` high: 1 cycle.
- FETCH → DECODE: 1 cycle (ROM latency).
- Write entry overhead excluding I2C wait: FETCH, DECODE, ISSUE = 3 cycles minimum to `i2c_valid_o` high.
- Delay entry xx: exactly 2 + xx·DELAY_UNIT cycles from FETCH to the next FETCH.
- `i2c_done_i` already high on entry to WAIT_DONE is not counted; a fresh rising edge is required.
- Counter widths: delay counter holds 255·DELAY_UNIT; timeout counter holds DONE_TIMEOUT. Both use $clog2 sizing and never overflow.

## Structure
- Package `camera_config_pkg` holds:
  - the state enum;
  - `CFG_END` = 16'hFFFF;
  - `CFG_DELAY_TAG` = 8'hFE.
- Natural sub-module: `camera_config_rom`, a synchronous ROM with ROM_AW address bits and 16-bit words. It is instantiated beside this block at top level, not inside it.
- The sequencer is flat: one FSM plus index, delay and timeout counters.

## Test plan
- Table {1280, 1204, FFFF}, I2C model accepts in 3 cycles and pulses done 500 cycles later → two writes, data 16'h1280 then 16'h1204, `config_done_o` = 1, `error_o` = 0.
- Table {FE02, 1100, FFFF}, DELAY_UNIT = 10 → `i2c_valid_o` first rises 2 + 20 + 3 = 25 cycles after FETCH of entry 0.
- I2C model never asserts done, DONE_TIMEOUT = 1000 → `error_o` = 1 within 1000 + 4 cycles of `i2c_valid_o`, `config_done_o` = 0, `i2c_valid_o` = 0, state IDLE.
- `i2c_ready_i` held 0 for 50 cycles after DECODE → `i2c_valid_o` stays 0 until ready, then a single request. `i2c_write_data_o` is stable for the whole transfer.
- Assert `reset_ni` = 0 in WAIT_DONE → all outputs 0 in the same cycle. After release, a new `start_i` replays from entry 0.
- ROM_AW = 2, table with no end marker → exactly 4 writes, then `config_done_o` = 1. Address never returns to 0 during the sequence.

Source files
------------

// File: rtl/camera_config_pkg.sv
// -----------------------------------------------------------------------------
// camera_config_pkg
//   Shared definitions for the camera configuration slice: the sequencer state
//   encoding and the two reserved table-word patterns (end marker, delay tag).
// -----------------------------------------------------------------------------
package camera_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    DELAY,
    FINISH
  } cfg_state_e;

  // Whole-word end-of-table marker.
  localparam logic [15:0] CFG_END       = 16'hFFFF;
  // Upper byte tagging a settle-delay entry; the lower byte is the unit count.
  localparam logic [7:0]  CFG_DELAY_TAG = 8'hFE;

  function automatic logic is_delay_entry(input logic [15:0] word);
    return (word[15:8] == CFG_DELAY_TAG);
  endfunction

endpackage

// File: rtl/camera_config_rom.sv
// -----------------------------------------------------------------------------
// camera_config_rom
//   Synchronous camera-init table: 2^ROM_AW words of {reg, data}, read data is
//   valid one clk_i cycle after the address. Sits beside the sequencer at the
//   top level, feeding its rom_data_i from its rom_addr_o.
//
// Ports
//   clk_i   system clock
//   addr_i  table address (ROM_AW bits)
//   data_o  registered table word (16 bits)
//
// ROM_INIT packs entry k into bits [16*k +: 16]; the default fills the table
// with end markers so an unprogrammed instance finishes immediately.
// -----------------------------------------------------------------------------
module camera_config_rom #(
  parameter int unsigned                 ROM_AW   = 6,
  parameter logic [16*(2**ROM_AW)-1:0]   ROM_INIT = '1
) (
  input  logic              clk_i,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [15:0]       data_o
);

  // NOTE: table storage and its read register carry no reset; a ROM holds
  // constants, and resetting the output would only add a mux in front of it.
  always_ff @(posedge clk_i) begin
    data_o <= ROM_INIT[{addr_i, 4'h0} +: 16];
  end

endmodule

// File: rtl/camera_config_sequencer.sv
// -----------------------------------------------------------------------------
// camera_config_sequencer
//   Walks the camera-init table one entry at a time and hands each register
//   write to the I2C write master. Table entries are either a {reg, data}
//   write, a settle delay (FExx = xx * DELAY_UNIT cycles) or the end marker
//   (FFFF). config_done_o releases the capture pipeline once a sequence has
//   completed; error_o reports a sequence abandoned on an I2C timeout.
//
// Ports
//   clk_i             system clock (single clock domain)
//   reset_ni          asynchronous active-low reset, deasserted synchronously
//   start_i           level request, acted on only while idle
//   rom_addr_o        table address (current index)
//   rom_data_i        table word, one cycle after rom_addr_o
//   i2c_write_data_o  {reg, data} presented to the I2C master
//   i2c_valid_o       write request to the I2C master
//   i2c_ready_i       I2C master idle
//   i2c_done_i        I2C transfer complete (pulse, ~one slow-clock period)
//   busy_o            sequence in progress
//   config_done_o     sticky: last sequence completed cleanly
//   error_o           sticky: last sequence aborted on timeout
// -----------------------------------------------------------------------------
module camera_config_sequencer
  import camera_config_pkg::*;
#(
  parameter int unsigned ROM_AW       = 6,
  parameter int unsigned DELAY_UNIT   = 100_000,
  parameter int unsigned DONE_TIMEOUT = 2_000_000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic [15:0]       i2c_write_data_o,
  output logic              i2c_valid_o,
  input  logic              i2c_ready_i,
  input  logic              i2c_done_i,
  output logic              busy_o,
  output logic              config_done_o,
  output logic              error_o
);

  localparam int unsigned DLY_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // Reset: assertion reaches every flop at once, release is retimed to clk_i.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // NOTE: every clocked block uses non-blocking assignments so all flops see
  // the pre-edge values of each other regardless of evaluation order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  cfg_state_e        state_q, state_d;
  logic [ROM_AW-1:0] idx_q;
  logic [15:0]       wdata_q;
  logic [DLY_W-1:0]  dly_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              done_q;
  logic              valid_q, busy_q, cfg_done_q, err_q;

  // FSM strobes
  logic start_seq, advance, idx_inc, ld_wdata, ld_delay, tmo_clr;
  logic set_done, set_err;

  logic done_rise, tmo_expired, last_entry;
  logic [DLY_W-1:0] delay_load;

  // done_q is the previous-cycle sample, so a done level already present when
  // WAIT_DONE is entered never looks like a fresh completion.
  assign done_rise   = i2c_done_i & ~done_q;
  assign tmo_expired = (tmo_q == TMO_W'(DONE_TIMEOUT - 1));
  assign last_entry  = (idx_q == {ROM_AW{1'b1}});
  // The DELAY state spends (count + 1) cycles, so load one less than the wait.
  assign delay_load  = DLY_W'(rom_data_i[7:0]) * DLY_W'(DELAY_UNIT) - DLY_W'(1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    start_seq = 1'b0;
    advance   = 1'b0;
    idx_inc   = 1'b0;
    ld_wdata  = 1'b0;
    ld_delay  = 1'b0;
    tmo_clr   = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_seq = 1'b1;
          state_d   = FETCH;
        end
      end

      FETCH: state_d = DECODE;

      DECODE: begin
        if (rom_data_i == CFG_END) begin
          state_d = FINISH;
        end else if (is_delay_entry(rom_data_i)) begin
          // A zero-length delay moves straight on, keeping FETCH-to-FETCH at 2.
          if (rom_data_i[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            ld_delay = 1'b1;
            state_d  = DELAY;
          end
        end else begin
          ld_wdata = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        if (i2c_ready_i) begin
          tmo_clr = 1'b1;
          state_d = WAIT_ACCEPT;
        end
      end

      WAIT_ACCEPT: begin
        if (tmo_expired) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else if (!i2c_ready_i) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (done_rise) begin
          advance = 1'b1;
        end else if (tmo_expired) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end

      DELAY: begin
        if (dly_q == '0) advance = 1'b1;
      end

      FINISH: begin
        set_done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // The final table slot ends the sequence instead of wrapping to entry 0.
    if (advance) begin
      if (last_entry) begin
        state_d = FINISH;
      end else begin
        idx_inc = 1'b1;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      dly_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q  <= i2c_done_i;
      // Request and busy are registered off the next state so the slow I2C
      // master samples glitch-free levels with no added latency.
      valid_q <= (state_d == WAIT_ACCEPT);
      busy_q  <= (state_d != IDLE);

      if (start_seq)    idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + ROM_AW'(1);

      if (ld_wdata) wdata_q <= rom_data_i;

      if (ld_delay)                                dly_q <= delay_load;
      else if (state_q == DELAY && dly_q != '0)    dly_q <= dly_q - DLY_W'(1);

      // One budget covers both acceptance and completion of a write.
      if (tmo_clr)                                          tmo_q <= '0;
      else if (state_q == WAIT_ACCEPT || state_q == WAIT_DONE) tmo_q <= tmo_q + TMO_W'(1);

      if (start_seq) begin
        cfg_done_q <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        if (set_done) cfg_done_q <= 1'b1;
        if (set_err)  err_q      <= 1'b1;
      end
    end
  end

  assign rom_addr_o       = idx_q;
  assign i2c_write_data_o = wdata_q;
  assign i2c_valid_o      = valid_q;
  assign busy_o           = busy_q;
  assign config_done_o    = cfg_done_q;
  assign error_o          = err_q;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_camera_config_sequencer
//   Directed bench for camera_config_sequencer: a behavioural synchronous ROM,
//   a behavioural I2C write master with programmable accept/done latency, and
//   one task per scenario with its own expected values.
// -----------------------------------------------------------------------------
module tb_camera_config_sequencer;

  localparam int ROM_AW       = 2;
  localparam int DELAY_UNIT   = 10;
  localparam int DONE_TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data = 16'h0;
  logic [15:0]       i2c_wdata;
  logic              i2c_valid;
  logic              i2c_ready;
  logic              i2c_done;
  logic              busy;
  logic              config_done;
  logic              cfg_error;

  int checks = 0;
  int errors = 0;

  // Table and I2C model controls
  logic [15:0] tb_rom [4];
  int          accept_lat  = 3;
  int          done_lat    = 500;
  bit          never_done  = 1'b0;
  bit          model_busy  = 1'b0;
  int          n_writes    = 0;
  int          stable_err  = 0;
  int          valid_rises = 0;
  logic [15:0] wr_log [8];
  logic        valid_prev  = 1'b0;

  always #5 clk = ~clk;

  camera_config_sequencer #(
    .ROM_AW      (ROM_AW),
    .DELAY_UNIT  (DELAY_UNIT),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .start_i         (start),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .i2c_write_data_o(i2c_wdata),
    .i2c_valid_o     (i2c_valid),
    .i2c_ready_i     (i2c_ready),
    .i2c_done_i      (i2c_done),
    .busy_o          (busy),
    .config_done_o   (config_done),
    .error_o         (cfg_error)
  );

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_data <= tb_rom[rom_addr];

  // Count request rising edges.
  always @(negedge clk) begin
    if (i2c_valid && !valid_prev) valid_rises++;
    valid_prev = i2c_valid;
  end

  // I2C write master model.
  initial begin : i2c_model
    logic [15:0] cap;
    i2c_ready = 1'b1;
    i2c_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_valid && i2c_ready) begin
        model_busy = 1'b1;
        cap = i2c_wdata;
        if (n_writes < 8) wr_log[n_writes] = i2c_wdata;
        n_writes++;
        repeat (accept_lat) @(negedge clk);
        i2c_ready = 1'b0;
        if (never_done) begin
          for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
        end else begin
          repeat (done_lat) @(negedge clk);
          if (i2c_wdata !== cap) stable_err++;
          i2c_done = 1'b1;
          repeat (4) @(negedge clk);
          i2c_done = 1'b0;
        end
        i2c_ready  = 1'b1;
        model_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (stimulus and bounded waits only)
  // ---------------------------------------------------------------------------
  task automatic start_seq();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && !model_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_model(input int max_cyc);
    for (int i = 0; i < max_cyc && model_busy; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (i2c_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_valid, busy, config_done, cfg_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {i2c_valid, busy, config_done, cfg_error});
    end
    checks++;
    if (i2c_wdata !== 16'h0000 || rom_addr !== 2'd0) begin
      errors++;
      $display("FAIL reset_data_addr: got wdata %h addr %0d expected 0000 / 0", i2c_wdata, rom_addr);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic_writes();
    bit ok;
    tb_rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
    accept_lat = 3; done_lat = 500;
    n_writes = 0; valid_rises = 0; stable_err = 0;
    @(negedge clk);
    start = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_before: got %b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_1cyc: got %b expected 1", busy);
    end
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: sequence still busy after 3000 cycles");
    end
    checks++;
    if (n_writes !== 2 || valid_rises !== 2) begin
      errors++;
      $display("FAIL basic_count: got %0d writes %0d requests expected 2 / 2", n_writes, valid_rises);
    end
    checks++;
    if (wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1204) begin
      errors++;
      $display("FAIL basic_data: got %h %h expected 1280 1204", wr_log[0], wr_log[1]);
    end
    checks++;
    if (config_done !== 1'b1 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got done %b err %b expected 1 / 0", config_done, cfg_error);
    end
    checks++;
    if (stable_err !== 0) begin
      errors++;
      $display("FAIL basic_stable: got %0d data changes expected 0", stable_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    tb_rom = '{16'h1301, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    done_lat = 20; n_writes = 0;
    @(negedge clk);
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (config_done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_done: got done %b busy %b expected 1 / 0", ok, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || config_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy %b done %b expected 1 / 0", busy, config_done);
    end
    start = 1'b0;
    wait_idle(500, ok);
    checks++;
    if (!ok || n_writes !== 2 || wr_log[1] !== 16'h1301 || config_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got ok %b writes %0d data %h done %b expected 1 2 1301 1",
               ok, n_writes, wr_log[1], config_done);
    end
  endtask

  task automatic test_delay_timing();
    logic [15:0] dly_word [2];
    int          exp_cyc  [2];
    int          cyc;
    bit          ok;
    dly_word = '{16'hFE02, 16'hFE00};
    exp_cyc  = '{25, 5};
    done_lat = 20;
    for (int t = 0; t < 2; t++) begin
      tb_rom = '{dly_word[t], 16'h1100, 16'hFFFF, 16'hFFFF};
      n_writes = 0;
      start_seq();  // returns in the FETCH cycle of entry 0
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        cyc++;
        if (i2c_valid) break;
      end
      checks++;
      if (cyc !== exp_cyc[t]) begin
        errors++;
        $display("FAIL delay_latency_%h: got %0d cycles expected %0d", dly_word[t], cyc, exp_cyc[t]);
      end
      wait_idle(500, ok);
      checks++;
      if (!ok || n_writes !== 1 || wr_log[0] !== 16'h1100) begin
        errors++;
        $display("FAIL delay_write_%h: got ok %b writes %0d data %h expected 1 1 1100",
                 dly_word[t], ok, n_writes, wr_log[0]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    tb_rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    never_done = 1'b1; n_writes = 0;
    start_seq();
    wait_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_no_request: i2c_valid never rose");
    end
    cyc = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      cyc++;
      if (cfg_error) break;
    end
    checks++;
    if (cfg_error !== 1'b1 || cyc < 1000 || cyc > 1004) begin
      errors++;
      $display("FAIL tmo_latency: got err %b after %0d cycles expected 1 within 1000..1004", cfg_error, cyc);
    end
    checks++;
    if ({config_done, i2c_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_state: got done/valid/busy %b expected 000", {config_done, i2c_valid, busy});
    end
    wait_model(100);
    never_done = 1'b0;
  endtask

  task automatic test_ready_stall();
    bit ok;
    bit valid_bad = 1'b0;
    bit data_bad  = 1'b0;
    tb_rom = '{16'h1455, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    done_lat = 20; n_writes = 0; valid_rises = 0; stable_err = 0;
    @(negedge clk);
    i2c_ready = 1'b0;
    start_seq();
    @(negedge clk);  // DECODE
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i2c_valid !== 1'b0)     valid_bad = 1'b1;
      if (i2c_wdata !== 16'h1455) data_bad  = 1'b1;
    end
    i2c_ready = 1'b1;
    wait_idle(300, ok);
    checks++;
    if (valid_bad || data_bad) begin
      errors++;
      $display("FAIL stall_hold: got valid_seen %b data_changed %b expected 0 / 0", valid_bad, data_bad);
    end
    checks++;
    if (!ok || valid_rises !== 1 || n_writes !== 1 || wr_log[0] !== 16'h1455) begin
      errors++;
      $display("FAIL stall_single: got ok %b requests %0d writes %0d data %h expected 1 1 1 1455",
               ok, valid_rises, n_writes, wr_log[0]);
    end
    checks++;
    if (stable_err !== 0 || cfg_error !== 1'b0 || config_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: got changes %0d err %b done %b expected 0 0 1", stable_err, cfg_error, config_done);
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    tb_rom = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    accept_lat = 3; done_lat = 200;
    start_seq();
    wait_valid(20, ok);
    for (int i = 0; i < 20 && i2c_valid; i++) @(negedge clk);
    repeat (5) @(negedge clk);  // inside WAIT_DONE
    reset_n = 1'b0;
    #1;
    checks++;
    if ({i2c_valid, busy, config_done, cfg_error} !== 4'b0000 || i2c_wdata !== 16'h0 || rom_addr !== 2'd0) begin
      errors++;
      $display("FAIL rst_wait_done: got flags %b wdata %h addr %0d expected 0000 0000 0",
               {i2c_valid, busy, config_done, cfg_error}, i2c_wdata, rom_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_model(400);
    repeat (4) @(negedge clk);

    // Reset while the request is still raised.
    accept_lat = 20;
    start_seq();
    wait_valid(20, ok);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (i2c_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_accept: got valid %b busy %b expected 0 / 0", i2c_valid, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_model(400);
    repeat (4) @(negedge clk);
    accept_lat = 3; done_lat = 20;

    tb_rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF};
    n_writes = 0;
    start_seq();
    wait_idle(500, ok);
    checks++;
    if (!ok || n_writes !== 2 || wr_log[0] !== 16'h1280 || config_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_replay: got ok %b writes %0d first %h done %b expected 1 2 1280 1",
               ok, n_writes, wr_log[0], config_done);
    end
  endtask

  task automatic test_no_end_marker();
    bit ok = 1'b0;
    bit seen_nz = 1'b0;
    bit wrapped = 1'b0;
    tb_rom = '{16'h1101, 16'h1102, 16'h1103, 16'h1104};
    done_lat = 20; n_writes = 0;
    start_seq();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rom_addr != 2'd0) seen_nz = 1'b1;
      else if (seen_nz)     wrapped = 1'b1;
    end
    wait_model(100);
    checks++;
    if (!ok || wrapped) begin
      errors++;
      $display("FAIL wrap_addr: got ended %b wrapped %b expected 1 / 0", ok, wrapped);
    end
    checks++;
    if (n_writes !== 4 || wr_log[0] !== 16'h1101 || wr_log[3] !== 16'h1104) begin
      errors++;
      $display("FAIL wrap_writes: got %0d writes first %h last %h expected 4 1101 1104",
               n_writes, wr_log[0], wr_log[3]);
    end
    checks++;
    if (config_done !== 1'b1 || cfg_error !== 1'b0 || rom_addr !== 2'd3) begin
      errors++;
      $display("FAIL wrap_end: got done %b err %b addr %0d expected 1 0 3", config_done, cfg_error, rom_addr);
    end
  endtask

  initial begin
    tb_rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    test_reset();
    test_basic_writes();
    test_back_to_back();
    test_delay_timing();
    test_timeout();
    test_ready_stall();
    test_reset_mid_transfer();
    test_no_end_marker();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
